// File: rtl/fetch_unit.sv
// fetch_unit: owns the PC, issues reads to synchronous instruction memory and hands words downstream.
// Optional FETCH_PERF_CNT_EN adds a saturating fetch_count of accepted words.
module fetch_unit #(
  parameter int ADDR_W      = 10,
  parameter int DATA_W      = 16,
  parameter int RESET_PC    = 0,
  parameter int MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              instr_valid,
  input  logic              instr_ready
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]       fetch_count
`endif
);
  localparam logic [1:0] ISSUE = 2'd0;
  localparam logic [1:0] WAIT  = 2'd1;
  localparam logic [1:0] HOLD  = 2'd2;
  logic [1:0]        state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] pc_q, pc_d, ipc_q, ipc_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic              valid_q, valid_d;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pc_d    = pc_q;
    ipc_d   = ipc_q;
    instr_d = instr_q;
    valid_d = valid_q;
    if (redirect) begin
      pc_d    = redirect_addr;
      state_d = ISSUE;
      cnt_d   = '0;
      valid_d = 1'b0;
    end else if (!stall) begin
      case (state_q)
        ISSUE: begin
          state_d = WAIT;
          cnt_d   = '0;
        end
        WAIT: begin
          if (cnt_q == 3'(MEM_LATENCY - 1)) begin
            instr_d = mem_dout;
            ipc_d   = pc_q;
            valid_d = 1'b1;
            pc_d    = pc_q + 1'b1;
            state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HOLD: begin
          valid_d = instr_ready ? 1'b0 : valid_q;
          state_d = instr_ready ? ISSUE : HOLD;
        end
        default: state_d = ISSUE;
      endcase
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ISSUE;
      cnt_q   <= '0;
      pc_q    <= ADDR_W'(RESET_PC);
      ipc_q   <= '0;
      instr_q <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      ipc_q   <= ipc_d;
      instr_q <= instr_d;
      valid_q <= valid_d;
    end
  end
  assign mem_addr    = pc_q;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign instr_valid = valid_q;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fcnt_q, fcnt_d;
  assign fcnt_d = fcnt_q + 16'((valid_q && instr_ready && !stall && fcnt_q != 16'hFFFF) ? 1 : 0);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fcnt_q <= '0;
    else fcnt_q <= fcnt_d;
  end
  assign fetch_count = fcnt_q;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus a randomized run checked against a transaction-level model.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        reset, stall, redirect, instr_ready;
  logic [9:0]  redirect_addr, mem_addr, instr_pc;
  logic [15:0] mem_dout, instr;
  logic        instr_valid;
  logic [15:0] mem [1024];
  int checks = 0, errors = 0;
`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fetch_count;
`endif

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall(stall), .redirect(redirect),
    .redirect_addr(redirect_addr), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid),
    .instr_ready(instr_ready)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fetch_count)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) mem_dout <= mem[mem_addr];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; instr_ready = 1'b0; redirect_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 10'd0 || instr !== 16'd0 || instr_pc !== 10'd0) begin
      errors++;
      $display("FAIL reset: valid=%b addr=%h instr=%h pc=%h, want 0 0 0 0", instr_valid, mem_addr, instr, instr_pc);
    end
    do_reset();
  endtask

  task automatic test_stream();
    logic [15:0] exp_w [3];
    exp_w[0] = 16'h1234; exp_w[1] = 16'hABCD; exp_w[2] = 16'h0F0F;
    do_reset();
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL stream_early: valid=%b want 0", instr_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== exp_w[i] || instr_pc !== 10'(i)) begin
        errors++;
        $display("FAIL stream_word%0d: valid=%b instr=%h pc=%h, want 1 %h %h", i, instr_valid, instr, instr_pc, exp_w[i], 10'(i));
      end
      if (i < 2) begin tick(); tick(); end
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    repeat (2) tick();
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (instr_valid !== 1'b1 || instr !== 16'h1234 || mem_addr !== 10'd1) begin
        errors++;
        $display("FAIL backpressure%0d: valid=%b instr=%h addr=%h, want 1 1234 001", i, instr_valid, instr, mem_addr);
      end
    end
    instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 10'd1) begin
      errors++;
      $display("FAIL bp_release: valid=%b addr=%h, want 0 001", instr_valid, mem_addr);
    end
    repeat (2) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'hABCD || instr_pc !== 10'd1) begin
      errors++;
      $display("FAIL bp_next: valid=%b instr=%h pc=%h, want 1 abcd 001", instr_valid, instr, instr_pc);
    end
  endtask

  task automatic test_redirect_wait();
    do_reset();
    instr_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_addr = 10'h3FE;
    tick();
    redirect = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 10'h3FE) begin
      errors++;
      $display("FAIL redir_wait: valid=%b addr=%h, want 0 3fe", instr_valid, mem_addr);
    end
    tick();
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL redir_pending: valid=%b want 0", instr_valid); end
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h5555 || instr_pc !== 10'h3FE || mem_addr !== 10'h3FF) begin
      errors++;
      $display("FAIL redir_word: valid=%b instr=%h pc=%h addr=%h, want 1 5555 3fe 3ff", instr_valid, instr, instr_pc, mem_addr);
    end
    repeat (3) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h6666 || instr_pc !== 10'h3FF || mem_addr !== 10'h000) begin
      errors++;
      $display("FAIL wrap: valid=%b instr=%h pc=%h addr=%h, want 1 6666 3ff 000", instr_valid, instr, instr_pc, mem_addr);
    end
  endtask

  task automatic test_stall_redirect_hold();
    do_reset();
    repeat (2) tick();
    stall = 1'b1; instr_ready = 1'b1;
    tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h1234 || mem_addr !== 10'd1) begin
      errors++;
      $display("FAIL stall_hold: valid=%b instr=%h addr=%h, want 1 1234 001", instr_valid, instr, mem_addr);
    end
    redirect = 1'b1; redirect_addr = 10'h010;
    tick();
    redirect = 1'b0; stall = 1'b0;
    checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 10'h010 || instr !== 16'h1234) begin
      errors++;
      $display("FAIL stall_redir: valid=%b addr=%h instr=%h, want 0 010 1234", instr_valid, mem_addr, instr);
    end
    repeat (2) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== mem[16] || instr_pc !== 10'h010) begin
      errors++;
      $display("FAIL stall_redir_word: valid=%b instr=%h pc=%h, want 1 %h 010", instr_valid, instr, instr_pc, mem[16]);
    end
  endtask

  task automatic test_reset_midwait();
    do_reset();
    instr_ready = 1'b1;
    repeat (4) tick();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (instr_valid !== 1'b0 || mem_addr !== 10'd0 || instr !== 16'd0 || instr_pc !== 10'd0) begin
      errors++;
      $display("FAIL reset_midwait: valid=%b addr=%h instr=%h pc=%h, want 0 000 0000 000", instr_valid, mem_addr, instr, instr_pc);
    end
    @(negedge clk);
    reset = 1'b0;
    repeat (2) tick();
    checks++;
    if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 10'd0) begin
      errors++;
      $display("FAIL reset_restart: valid=%b instr=%h pc=%h, want 1 1234 000", instr_valid, instr, instr_pc);
    end
  endtask

`ifdef FETCH_PERF_CNT_EN
  task automatic test_perf();
    do_reset();
    instr_ready = 1'b1;
    repeat (11) tick();
    stall = 1'b1;
    tick();
    stall = 1'b0; instr_ready = 1'b0;
    tick();
    checks++;
    if (fetch_count !== 16'd3 || instr_valid !== 1'b1) begin
      errors++;
      $display("FAIL perf: count=%0d valid=%b, want 3 1", fetch_count, instr_valid);
    end
  endtask
`endif

  task automatic test_random();
    logic [9:0]  exp_pc, p_addr, p_ipc, p_mem;
    logic [15:0] p_instr;
    logic        p_stall, p_redir, p_ready, p_valid;
    int          words = 0;
    do_reset();
    exp_pc = 10'd0;
    for (int c = 0; c < 3000; c++) begin
      p_stall = ($urandom_range(0, 99) < 20);
      p_redir = ($urandom_range(0, 99) < 4);
      p_ready = ($urandom_range(0, 99) < 60);
      p_addr  = 10'($urandom);
      p_valid = instr_valid; p_instr = instr; p_ipc = instr_pc; p_mem = mem_addr;
      stall = p_stall; redirect = p_redir; instr_ready = p_ready; redirect_addr = p_addr;
      tick();
      if (p_redir) begin
        exp_pc = p_addr;
        checks++;
        if (instr_valid !== 1'b0 || mem_addr !== p_addr) begin
          errors++;
          $display("FAIL rnd_redir c%0d: valid=%b addr=%h, want 0 %h", c, instr_valid, mem_addr, p_addr);
        end
      end else if (p_valid) begin
        checks++;
        if (p_ready && !p_stall) begin
          if (instr_valid !== 1'b0) begin errors++; $display("FAIL rnd_consume c%0d: valid=%b want 0", c, instr_valid); end
        end else if (instr_valid !== 1'b1 || instr !== p_instr || instr_pc !== p_ipc) begin
          errors++;
          $display("FAIL rnd_hold c%0d: valid=%b instr=%h pc=%h, want 1 %h %h", c, instr_valid, instr, instr_pc, p_instr, p_ipc);
        end
      end else if (instr_valid) begin
        checks++;
        words++;
        if (instr_pc !== exp_pc || instr !== mem[exp_pc] || mem_addr !== exp_pc + 10'd1) begin
          errors++;
          $display("FAIL rnd_word c%0d: instr=%h pc=%h addr=%h, want %h %h %h", c, instr, instr_pc, mem_addr, mem[exp_pc], exp_pc, exp_pc + 10'd1);
        end
        exp_pc = exp_pc + 10'd1;
      end
      if (p_stall && !p_redir) begin
        checks++;
        if (mem_addr !== p_mem) begin errors++; $display("FAIL rnd_stall_pc c%0d: addr=%h want %h", c, mem_addr, p_mem); end
      end
      if (!instr_valid) begin
        checks++;
        if (instr !== p_instr || instr_pc !== p_ipc) begin
          errors++;
          $display("FAIL rnd_idle_stable c%0d: instr=%h pc=%h, want %h %h", c, instr, instr_pc, p_instr, p_ipc);
        end
      end
    end
    checks++;
    if (words < 50) begin errors++; $display("FAIL rnd_progress: words=%0d want >=50", words); end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 16'($urandom);
    mem[0] = 16'h1234; mem[1] = 16'hABCD; mem[2] = 16'h0F0F;
    mem[10'h3FE] = 16'h5555; mem[10'h3FF] = 16'h6666;
    reset = 1'b1; stall = 1'b0; redirect = 1'b0; instr_ready = 1'b0; redirect_addr = '0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_wait();
    test_stall_redirect_hold();
    test_reset_midwait();
`ifdef FETCH_PERF_CNT_EN
    test_perf();
`endif
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch stage of the 16-bit processor; sits directly upstream of the instruction memory/control block.
- Owns the program counter and drives the 10-bit memory address.
- Waits out the synchronous-read latency, captures the returned 16-bit word into an instruction register and offers it downstream with a valid/ready handshake.
- Accepts branch/jump redirects from the execute stage.

Parameters:
- ADDR_W, 10, width of PC and memory address.
- DATA_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- MEM_LATENCY, 1, memory read latency in clock edges after the address is sampled; legal range 1..7.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- stall  in  1  freeze fetch progress; redirect still honoured.
- redirect  in  1  load PC from redirect_addr and flush the in-flight fetch.
- redirect_addr  in  ADDR_W  new PC target.
- mem_addr  out  ADDR_W  address to instruction memory; equals the registered PC.
- mem_dout  in  DATA_W  read data from instruction memory (douta).
- instr  out  DATA_W  captured instruction word.
- instr_pc  out  ADDR_W  address the captured instruction came from.
- instr_valid  out  1  instr/instr_pc hold a valid, unconsumed word.
- instr_ready  in  1  downstream accepts the word this cycle.

Behaviour:
- Reset: applied asynchronously on reset high.
  - pc and mem_addr = RESET_PC.
  - instr = 0, instr_pc = 0, instr_valid = 0.
  - state = ISSUE, latency counter = 0.
  - After reset deasserts, operation starts at the next rising edge.
- mem_addr is always the pc register; it never changes outside the PC-update rules below.
- State machine, one state register:
  - ISSUE: address stable for one cycle; the memory samples it at the closing edge. Next state WAIT, counter cleared.
  - WAIT: counter increments each cycle. On the cycle where counter == MEM_LATENCY-1, the closing edge does the following:
    - instr <= mem_dout, instr_pc <= pc, instr_valid <= 1.
    - pc <= pc + 1, modulo 2^ADDR_W (2^ADDR_W-1 wraps to 0).
    - state <= HOLD.
  - HOLD: instr_valid = 1, and instr/instr_pc are held stable. If instr_ready = 1 this cycle, the word is consumed: instr_valid <= 0, state <= ISSUE. Otherwise stay in HOLD.
- Latency: with MEM_LATENCY = 1, instr_valid rises 2 cycles after entering ISSUE. Best-case throughput is one instruction per MEM_LATENCY + 2 cycles.
- stall = 1 (without redirect):
  - No state, counter, pc or instr change.
  - A HOLD-state acceptance is also blocked, so instr_valid stays 1.
- Redirect has highest priority after reset and overrides stall in any state:
  - pc <= redirect_addr; state <= ISSUE; counter cleared.
  - Any in-flight read is discarded, never captured.
  - instr_valid <= 0. In HOLD with instr_ready = 1 in the same cycle, the word counts as consumed; otherwise it is dropped.
- Consecutive redirects: each one restarts at ISSUE with the latest target.
- instr and instr_pc keep their last values while instr_valid = 0.
- Reset asserted mid-WAIT or mid-HOLD: everything returns to reset values immediately, with no capture.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined: adds output port fetch_count (16 bits).
  - Reset value 0.
  - Increments by 1 on every cycle where instr_valid & instr_ready & !stall.
  - Saturates at 0xFFFF.
- Not defined: port and counter are absent; all other behaviour is identical.

Test Plan:
- Memory preload: addr0 = 0x1234, addr1 = 0xABCD, addr2 = 0x0F0F.
  - Release reset, hold instr_ready = 1.
  - Required: instr 0x1234 / instr_pc 0 valid 2 cycles after the first ISSUE, then 0xABCD / pc 1, then 0x0F0F / pc 2, each 3 cycles apart.
- Backpressure: instr_ready = 0 for 5 cycles once instr_valid rises.
  - Required: instr stays 0x1234, instr_valid stays 1, mem_addr stays 1.
  - Raise instr_ready: valid drops the next cycle and the fetch of addr1 starts.
- Redirect during WAIT to addr 0x3FE (preloaded 0x5555).
  - Required: the pending word is never presented; next valid word is 0x5555 / pc 0x3FE.
  - After 0x3FF is fetched, mem_addr wraps to 0.
- Stall and redirect asserted together in HOLD.
  - Required: redirect wins; instr_valid = 0 the next cycle; pc = redirect_addr.
- Reset pulsed mid-WAIT.
  - Required: instr_valid = 0 immediately, mem_addr = RESET_PC; the fetch restarts from 0 and returns 0x1234.
- With FETCH_PERF_CNT_EN, 3 accepted words plus one accepted-but-stalled cycle.
  - Required: fetch_count = 3.
